// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CHECK,
      ST_FILL,
      ST_RUN,
      ST_ERR
   } state_t;

   localparam int LEN_W = 16;
   localparam int CHK_W = 8;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream LSB-first into 32-bit words and keeps a running XOR of every byte.
module byte_word_packer
   import loader_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [7:0]       data,
   output logic             word_valid,
   output logic [31:0]      word,
   output logic [CHK_W-1:0] checksum
);

   logic [1:0]       count_reg;
   logic [23:0]      shift_reg;
   logic [CHK_W-1:0] chk_reg;

   // Only the first three bytes are stored; the fourth is merged combinationally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
         shift_reg <= '0;
         chk_reg   <= '0;
      end else if (clear) begin
         count_reg <= '0;
         shift_reg <= '0;
         chk_reg   <= '0;
      end else if (push) begin
         count_reg <= count_reg + 2'd1;
         shift_reg <= {data, shift_reg[23:8]};
         chk_reg   <= chk_reg ^ data;
      end
   end

   assign word_valid = push && (count_reg == 2'd3);
   assign word       = {data, shift_reg};
   assign checksum   = chk_reg;

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a framed image, writes instruction memory, pads with NOPs,
// verifies the XOR checksum and releases the core from reset on success.
module program_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_WIDTH = 5,
   parameter logic [31:0] NOP_WORD   = loader_pkg::NOP_WORD
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  done,
   output logic                  error,
   output logic [LEN_W-1:0]      words_loaded
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [LEN_W:0] DEPTH_EXT = (LEN_W + 1)'(DEPTH);

   state_t                state_reg, state_next;
   logic [LEN_W-1:0]      len_reg, len_next;
   logic [LEN_W-1:0]      words_reg, words_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [31:0]           wdata_reg, wdata_next;
   logic                  we_reg, we_next;
   logic                  ready_reg, ready_next;
   logic                  done_reg, done_next;
   logic                  error_reg, error_next;
   logic                  core_reset_reg, core_reset_next;

   logic                  accept;
   logic                  pk_clear;
   logic                  pk_push;
   logic                  pk_word_valid;
   logic [31:0]           pk_word;
   logic [CHK_W-1:0]      pk_checksum;
   logic [LEN_W-1:0]      len_full;

   byte_word_packer u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (pk_clear),
      .push       (pk_push),
      .data       (byte_data),
      .word_valid (pk_word_valid),
      .word       (pk_word),
      .checksum   (pk_checksum)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         len_reg        <= '0;
         words_reg      <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         we_reg         <= 1'b0;
         ready_reg      <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
         core_reset_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         len_reg        <= len_next;
         words_reg      <= words_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         we_reg         <= we_next;
         ready_reg      <= ready_next;
         done_reg       <= done_next;
         error_reg      <= error_next;
         core_reset_reg <= core_reset_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      words_next = words_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      we_next    = 1'b0;
      pk_clear   = 1'b0;
      accept     = byte_valid && ready_reg;
      pk_push    = accept && (state_reg == ST_DATA);
      len_full   = {byte_data, len_reg[7:0]};

      case (state_reg)
         ST_IDLE, ST_RUN, ST_ERR: begin
            if (start) begin
               state_next = ST_LEN_LO;
               len_next   = '0;
               words_next = '0;
               pk_clear   = 1'b1;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_next[7:0] = byte_data;
               state_next    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_next = len_full;
               // Oversized images are rejected before any write so the address never wraps.
               if ({1'b0, len_full} > DEPTH_EXT)
                  state_next = ST_ERR;
               else if (len_full == '0)
                  state_next = ST_CHECK;
               else
                  state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (pk_word_valid) begin
               we_next    = 1'b1;
               addr_next  = words_reg[ADDR_WIDTH-1:0];
               wdata_next = pk_word;
               words_next = words_reg + 16'd1;
               if (words_next == len_reg)
                  state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (accept) begin
               if (byte_data == pk_checksum) begin
                  if ({1'b0, len_reg} == DEPTH_EXT) begin
                     state_next = ST_RUN;
                  end else begin
                     state_next = ST_FILL;
                     we_next    = 1'b1;
                     addr_next  = len_reg[ADDR_WIDTH-1:0];
                     wdata_next = NOP_WORD;
                  end
               end else begin
                  state_next = ST_ERR;
               end
            end
         end
         ST_FILL: begin
            // The first pad write was issued on entry; continue until the top address.
            if (addr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
               state_next = ST_RUN;
            end else begin
               we_next    = 1'b1;
               addr_next  = addr_reg + ADDR_WIDTH'(1);
               wdata_next = NOP_WORD;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      ready_next      = state_next inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
      done_next       = (state_next == ST_RUN);
      error_next      = (state_next == ST_ERR);
      core_reset_next = (state_next != ST_RUN);
   end

   assign byte_ready   = ready_reg;
   assign imem_we      = we_reg;
   assign imem_addr    = addr_reg;
   assign imem_wdata   = wdata_reg;
   assign core_reset   = core_reset_reg;
   assign done         = done_reg;
   assign error        = error_reg;
   assign words_loaded = words_reg;

endmodule
